// File: rtl/booth_mult_r4.sv
// booth_mult_r4 -- radix-4 Booth sequential multiplier with valid/ready on both sides.
//
// Retires two multiplier bits per cycle. A result takes ITER = WIDTH/2+1 cycles from the
// accepting edge. The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operands and mode present
//   in_ready   block can accept an operation (IDLE only)
//   sgn        1: A, B two's complement; 0: A, B unsigned
//   A, B       multiplicand, multiplier (WIDTH bits)
//   out_valid  M holds a completed product
//   out_ready  consumer takes M
//   M          2*WIDTH-bit product, held until the next DONE or reset
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN. When it is defined, a zero operand at
// acceptance finishes after one cycle with M=0.

module booth_mult_r4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] M
);

  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(ITER);
  localparam int unsigned XW   = WIDTH + 2;  // extended operand width
  localparam int unsigned PW   = WIDTH + 3;  // upper partial product, holds +/-2A

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [XW-1:0]        a_q, a_d;
  logic [PW-1:0]        p_q, p_d;
  logic [XW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   m_q, m_d;

  logic [XW-1:0]        a_ext, b_ext;
  logic [PW-1:0]        a_sx, a_x2, addend, sum;
  logic [2:0]           triplet;
  logic signed [PW+XW-1:0] shift_v;

  always_comb begin
    a_ext   = {{2{sgn & A[WIDTH-1]}}, A};
    b_ext   = {{2{sgn & B[WIDTH-1]}}, B};
    a_sx    = {a_q[XW-1], a_q};
    a_x2    = {a_q, 1'b0};
    triplet = {q_q[1:0], qm1_q};
    addend  = '0;
    unique case (triplet)
      3'b001, 3'b010: addend = a_sx;
      3'b011:         addend = a_x2;
      3'b100:         addend = -a_x2;
      3'b101, 3'b110: addend = -a_sx;
      default:        addend = '0;
    endcase
    sum     = p_q + addend;
    // Arithmetic shift of the combined {P, Q} register; the dropped q[1] becomes q[-1].
    shift_v = $signed({sum, q_q}) >>> 2;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_d       = p_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_ext;
          q_d     = b_ext;
          p_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef BOOTH_ZERO_SKIP_EN
          // A single all-zero iteration lands the product (0) in M after one cycle.
          if ((A == '0) || (B == '0)) begin
            q_d   = '0;
            cnt_d = CW'(ITER - 1);
          end
`else
`endif
        end
      end
      StCalc: begin
        p_d   = shift_v[PW+XW-1:XW];
        q_d   = shift_v[XW-1:0];
        qm1_d = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          m_d     = shift_v[2*WIDTH-1:0];
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  assign M = m_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4: table-driven vectors and random operations on a
// WIDTH=8 instance checked by a scoreboard, plus directed backpressure, reset and
// WIDTH=4 / WIDTH=16 spot checks.

module tb_booth_mult_r4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] m;

  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  m4;

  logic        v16, r16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] m16;

  booth_mult_r4 #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .M(m)
  );

  booth_mult_r4 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .sgn(s4),
    .A(a4), .B(b4), .out_valid(ov4), .out_ready(or4), .M(m4)
  );

  booth_mult_r4 #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .sgn(s16),
    .A(a16), .B(b16), .out_valid(ov16), .out_ready(or16), .M(m16)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] m;
    int          lat;
    int          acc;
  } sb_t;
  sb_t         sbq[$];
  logic [15:0] pend_m;
  int          pend_lat;
  bit          ov_prev;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] m;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic s);
    int xi, yi;
    logic [31:0] pr;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    pr = xi * yi;
    return pr[15:0];
  endfunction

  function automatic int lat8(input logic [7:0] x, input logic [7:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
    if ((x == 8'd0) || (y == 8'd0)) return 1;
`endif
    return 5;
  endfunction

  // Scoreboard monitor: push on acceptance, check latency on out_valid rise, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb_t e;
        e.m   = pend_m;
        e.lat = pend_lat;
        e.acc = cyc + 1;
        sbq.push_back(e);
      end
      if (out_valid && !ov_prev) begin
        check("scoreboard depth at out_valid", sbq.size(), 1);
        if (sbq.size() != 0) check("latency", cyc - sbq[0].acc, sbq[0].lat);
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        check("product", m, sbq[0].m);
        sbq.delete(0);
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
    @(posedge clk);
    #1;
    a        = x;
    b        = y;
    sgn      = s;
    pend_m   = ref8(x, y, s);
    pend_lat = lat8(x, y);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    sgn      = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    check("drain", sbq.size(), 0);
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi, lat;
    logic [31:0] pr;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    pr = xi * yi;
    @(posedge clk);
    #1;
    a4 = x; b4 = y; s4 = s; v4 = 1'b1;
    check("w4 in_ready", r4, 1);
    @(posedge clk);
    #1;
    v4  = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w4 latency", lat, 3);
    check("w4 product", m4, pr[7:0]);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint xi, yi;
    int lat;
    logic [63:0] pr;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    pr = xi * yi;
    @(posedge clk);
    #1;
    a16 = x; b16 = y; s16 = s; v16 = 1'b1;
    check("w16 in_ready", r16, 1);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w16 latency", lat, 9);
    check("w16 product", m16, pr[31:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] bp_exp;

    vecs[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};  // -128 x -128
    vecs[1]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};  // -128 x 127 = -16256
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};  // -1 x -1
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};  // 255 x 255
    vecs[4]  = '{8'h80, 8'h02, 1'b0, 16'h0100};  // 128 x 2
    vecs[5]  = '{8'h80, 8'h02, 1'b1, 16'hFF00};  // -128 x 2
    vecs[6]  = '{8'h00, 8'hB3, 1'b1, 16'h0000};  // 0 x -77
    vecs[7]  = '{8'h00, 8'hB3, 1'b0, 16'h0000};
    vecs[8]  = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};  // 7 x -3
    vecs[9]  = '{8'h64, 8'h64, 1'b0, 16'h2710};  // 100 x 100
    vecs[10] = '{8'hFF, 8'h80, 1'b0, 16'h7F80};  // 255 x 128
    vecs[11] = '{8'hB3, 8'h00, 1'b1, 16'h0000};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sgn = 1'b0;
    v4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; s4 = 1'b0;
    v16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; s16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset M", m, 0);
    check("reset in_ready", in_ready, 1);
    rst = 1'b0;

    // Table-driven vectors; the monitor checks products against the scoreboard too.
    for (int i = 0; i < 12; i++) begin
      check("table ref", ref8(vecs[i].a, vecs[i].b, vecs[i].s), vecs[i].m);
      send(vecs[i].a, vecs[i].b, vecs[i].s);
    end
    drain();

    // Random sweep in both modes.
    for (int i = 0; i < 400; i++) send(8'($urandom), 8'($urandom), 1'(i));
    drain();

    // Backpressure: result held while out_ready is low, inputs ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bp_exp = ref8(8'hC3, 8'h5A, 1'b1);
    send(8'hC3, 8'h5A, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check("bp M stable", m, bp_exp);
      check("bp in_ready", in_ready, 0);
      check("bp out_valid held", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp released out_valid", out_valid, 0);
    check("bp released in_ready", in_ready, 1);
    check("bp M retained", m, bp_exp);
    check("bp nothing accepted", sbq.size(), 0);

    // Asynchronous reset mid-CALC discards the operation.
    send(8'h05, 8'h06, 1'b1);
    #12;
    rst = 1'b1;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst M", m, 0);
    check("async rst in_ready", in_ready, 1);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'hF9, 8'h0D, 1'b1);  // -7 x 13
    drain();
    check("post-reset M", m, 16'hFFA5);

    // Other widths.
    op4(4'h8, 4'h8, 1'b1);
    op4(4'hF, 4'hF, 1'b0);
    op4(4'h7, 4'h9, 1'b1);
    for (int i = 0; i < 10; i++) op4(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'(i));
    op16(16'h8000, 16'h8000, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'h8000, 16'h7FFF, 1'b1);
    for (int i = 0; i < 10; i++)
      op16(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 1'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
